// File: rtl/cnn_tile_seq.sv
// Tile-loop sequencer for a convolution layer: walks row, col, output-channel tile,
// input-channel tile and kernel taps, emitting one beat per accepted handshake.
module cnn_tile_seq #(
  parameter int N_p  = 4,
  parameter int M_p  = 4,
  parameter int K_p  = 2,
  parameter int R_p  = 16,
  parameter int C_p  = 16,
  parameter int S_p  = 1,
  parameter int Tn_p = 2,
  parameter int Tm_p = 2,
  localparam int RW  = (R_p > 1) ? $clog2(R_p) : 1,
  localparam int CW  = (C_p > 1) ? $clog2(C_p) : 1,
  localparam int TOW = $clog2(M_p) + 1,
  localparam int TIW = $clog2(N_p) + 1,
  localparam int KW  = $clog2(K_p) + 1,
  localparam int IW  = $clog2(S_p * R_p + K_p) + 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            start_i,
  input  logic            ready_i,
  output logic            valid_o,
  output logic [RW-1:0]   row_o,
  output logic [CW-1:0]   col_o,
  output logic [TOW-1:0]  to_o,
  output logic [TIW-1:0]  ti_o,
  output logic [KW-1:0]   ki_o,
  output logic [KW-1:0]   kj_o,
  output logic [IW-1:0]   in_row_o,
  output logic [IW-1:0]   in_col_o,
  output logic            pad_o,
  output logic [Tn_p-1:0] n_mask_o,
  output logic [Tm_p-1:0] m_mask_o,
  output logic            first_o,
  output logic            last_o,
  output logic            busy_o,
  output logic            done_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;
  state_t r_state;

  logic w_kj_wrap, w_ki_wrap, w_ti_wrap, w_to_wrap, w_col_wrap, w_row_wrap;
  logic w_final, w_load;
  logic [RW-1:0]   w_row_n;
  logic [CW-1:0]   w_col_n;
  logic [TOW-1:0]  w_to_n;
  logic [TIW-1:0]  w_ti_n;
  logic [KW-1:0]   w_ki_n, w_kj_n;
  logic [IW-1:0]   w_in_row, w_in_col;
  logic            w_pad, w_first, w_last;
  logic [Tn_p-1:0] w_nmask;
  logic [Tm_p-1:0] w_mmask;

  // Next beat: zeros when launching from IDLE, otherwise a ripple carry from kj upward.
  always_comb begin
    w_kj_wrap  = (int'(kj_o) == K_p - 1);
    w_ki_wrap  = (int'(ki_o) == K_p - 1);
    w_ti_wrap  = (int'(ti_o) + Tn_p >= N_p);
    w_to_wrap  = (int'(to_o) + Tm_p >= M_p);
    w_col_wrap = (int'(col_o) == C_p - 1);
    w_row_wrap = (int'(row_o) == R_p - 1);
    w_final    = w_kj_wrap && w_ki_wrap && w_ti_wrap && w_to_wrap && w_col_wrap && w_row_wrap;
    w_load     = ((r_state == S_IDLE) && start_i) ||
                 ((r_state == S_RUN) && ready_i && !w_final);
    w_row_n = '0;
    w_col_n = '0;
    w_to_n  = '0;
    w_ti_n  = '0;
    w_ki_n  = '0;
    w_kj_n  = '0;
    if (r_state == S_RUN) begin
      w_row_n = row_o;
      w_col_n = col_o;
      w_to_n  = to_o;
      w_ti_n  = ti_o;
      w_ki_n  = ki_o;
      w_kj_n  = w_kj_wrap ? '0 : kj_o + KW'(1);
      if (w_kj_wrap) begin
        w_ki_n = w_ki_wrap ? '0 : ki_o + KW'(1);
        if (w_ki_wrap) begin
          w_ti_n = w_ti_wrap ? '0 : ti_o + TIW'(Tn_p);
          if (w_ti_wrap) begin
            w_to_n = w_to_wrap ? '0 : to_o + TOW'(Tm_p);
            if (w_to_wrap) begin
              w_col_n = w_col_wrap ? '0 : col_o + CW'(1);
              if (w_col_wrap) w_row_n = w_row_wrap ? '0 : row_o + RW'(1);
            end
          end
        end
      end
    end
    w_in_row = IW'(S_p) * IW'(w_row_n) + IW'(w_ki_n);
    w_in_col = IW'(S_p) * IW'(w_col_n) + IW'(w_kj_n);
    w_pad    = (int'(w_in_row) >= R_p) || (int'(w_in_col) >= C_p);
    w_nmask  = '0;
    for (int n = 0; n < Tn_p; n++) w_nmask[n] = (int'(w_ti_n) + n < N_p);
    w_mmask  = '0;
    for (int m = 0; m < Tm_p; m++) w_mmask[m] = (int'(w_to_n) + m < M_p);
    w_first  = (w_ti_n == '0) && (w_ki_n == '0) && (w_kj_n == '0);
    w_last   = (int'(w_ti_n) + Tn_p >= N_p) && (int'(w_ki_n) == K_p - 1) &&
               (int'(w_kj_n) == K_p - 1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state  <= S_IDLE;
      valid_o  <= 1'b0;
      busy_o   <= 1'b0;
      done_o   <= 1'b0;
      row_o    <= '0;
      col_o    <= '0;
      to_o     <= '0;
      ti_o     <= '0;
      ki_o     <= '0;
      kj_o     <= '0;
      in_row_o <= '0;
      in_col_o <= '0;
      pad_o    <= 1'b0;
      n_mask_o <= '1;
      m_mask_o <= '1;
      first_o  <= 1'b0;
      last_o   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: if (start_i) begin
          r_state <= S_RUN;
          valid_o <= 1'b1;
          busy_o  <= 1'b1;
        end
        S_RUN: if (ready_i && w_final) begin
          r_state <= S_DONE;
          valid_o <= 1'b0;
          done_o  <= 1'b1;
        end
        S_DONE: begin
          r_state <= S_IDLE;
          done_o  <= 1'b0;
          busy_o  <= 1'b0;
        end
        default: r_state <= S_IDLE;
      endcase
      if (w_load) begin
        row_o    <= w_row_n;
        col_o    <= w_col_n;
        to_o     <= w_to_n;
        ti_o     <= w_ti_n;
        ki_o     <= w_ki_n;
        kj_o     <= w_kj_n;
        in_row_o <= w_in_row;
        in_col_o <= w_in_col;
        pad_o    <= w_pad;
        n_mask_o <= w_nmask;
        m_mask_o <= w_mmask;
        first_o  <= w_first;
        last_o   <= w_last;
      end
    end
  end

endmodule

// File: doc/cnn_tile_seq.md
CNN_TILE_SEQ -- requirements
Module: cnn_tile_seq

Interface
REQ-001 Parameter N_p, default 4: input feature-map channels.
REQ-002 Parameter M_p, default 4: output feature-map channels.
REQ-003 Parameter K_p, default 2: kernel height and width.
REQ-004 Parameters R_p and C_p, default 16 each: output rows and columns; the input map is also R_p x C_p.
REQ-005 Parameter S_p, default 1: convolution stride.
REQ-006 Parameters Tn_p and Tm_p, default 2 each: input-channel and output-channel tile sizes.
REQ-007 clk  input  1  single clock; all state changes on its rising edge.
REQ-008 reset  input  1  asynchronous, active-low reset: reset=0 forces reset state immediately, independent of clk.
REQ-009 start_i  input  1  one-cycle request to sweep a full layer.
REQ-010 ready_i  input  1  downstream compute engine accepts the current beat.
REQ-011 valid_o  output  1  beat fields are valid.
REQ-012 row_o / col_o  output  $clog2(R_p) / $clog2(C_p)  output pixel.
REQ-013 to_o / ti_o  output  $clog2(M_p)+1 / $clog2(N_p)+1  base output/input channel of the tile.
REQ-014 ki_o / kj_o  output  $clog2(K_p)+1 each  kernel tap.
REQ-015 in_row_o / in_col_o  output  $clog2(S_p*R_p+K_p)+1  input coordinate: S_p*row+ki and S_p*col+kj.
REQ-016 pad_o  output  1  in_row_o>=R_p or in_col_o>=C_p; the consumer substitutes zero for fm data.
REQ-017 n_mask_o / m_mask_o  output  Tn_p / Tm_p  bit n set iff ti_o+n<N_p; bit m set iff to_o+m<M_p.
REQ-018 first_o / last_o  output  1  first/last beat contributing to the current output tile (accumulator clear / writeback).
REQ-019 busy_o / done_o  output  1  sweep in progress; one-cycle completion pulse.

Function
REQ-020 The block SHALL implement states IDLE, RUN and DONE.
REQ-021 In IDLE, start_i=1 SHALL move the block to RUN and assert valid_o with beat 0 on the next cycle.
REQ-022 Loop order, outermost to innermost, SHALL be row, col, to (step Tm_p), ti (step Tn_p), ki, kj; kj changes fastest.
REQ-023 The block SHALL advance exactly one beat per cycle in which valid_o&ready_i=1.
REQ-024 While valid_o=1 and ready_i=0, every output field SHALL hold stable.
REQ-025 Total beats per sweep SHALL equal R_p*C_p*ceil(M_p/Tm_p)*ceil(N_p/Tn_p)*K_p*K_p.
REQ-026 first_o SHALL be 1 iff ti_o=0, ki_o=0 and kj_o=0.
REQ-027 last_o SHALL be 1 iff ti_o is the last ti step, ki_o=K_p-1 and kj_o=K_p-1.
REQ-028 When the final beat handshakes, the block SHALL deassert valid_o and enter DONE, then pulse done_o=1 for one cycle and return to IDLE.
REQ-029 busy_o SHALL be 1 in RUN and DONE.
REQ-030 start_i SHALL be ignored in RUN and DONE.
REQ-031 start_i in the IDLE cycle immediately following DONE SHALL be accepted.
REQ-032 Counters SHALL wrap to 0 on the carry to the next loop level.
REQ-033 No counter SHALL exceed its bound, including when N_p or M_p is not a multiple of its tile size.
REQ-034 All outputs SHALL be registered.
REQ-035 Combinational paths from ready_i to valid_o SHALL be allowed only through the state update, never directly.

Reset
REQ-036 On reset=0: state=IDLE, and valid_o, busy_o, done_o, first_o, last_o and pad_o SHALL be 0.
REQ-037 On reset=0: all index outputs SHALL be 0, and both masks SHALL be all ones.
REQ-038 Reset asserted mid-sweep SHALL abort the sweep with no further beats.
REQ-039 After release from reset, the block SHALL wait for a new start_i.

Verification
REQ-040 Defaults, start_i pulse, ready_i=1 constant -> valid_o from the next cycle for exactly 4096 cycles, then done_o for one cycle; beat 4 has ti_o=2, ki_o=0, kj_o=0; beat 8 has to_o=2; beat 16 has col_o=1.
REQ-041 Defaults, ready_i held 0 for 5 cycles at beat 3 -> all fields frozen at beat 3 (kj_o=1, ki_o=1, first_o=0) throughout, and the beat count stays 4096.
REQ-042 Defaults, beat with row_o=15, ki_o=1 -> in_row_o=16, pad_o=1; row_o=14, ki_o=1 -> pad_o=0.
REQ-043 N_p=3, Tn_p=2 -> beats with ti_o=0 show n_mask_o=2'b11, beats with ti_o=2 show 2'b01, and last_o coincides with ti_o=2, ki_o=1, kj_o=1.
REQ-044 reset driven to 0 at beat 100, start_i pulsed during RUN, and reset released before a new start_i -> start_i in RUN has no effect; after reset, valid_o=0, busy_o=0, and no beat appears until a new start_i, which restarts at beat 0.
